// File: rtl/lw_sha_bus_host_sequencer.sv
// lw_sha_bus_host_sequencer: bus master that runs one SHA hash job through the SHA register interface.
//
// Takes an opcode and a stream of message words from the host. For each job it writes CFG, then CTL.init,
// and streams every message word into DIN, waiting for STS.rdyd before each one. It then writes CTL.last,
// polls STS.avl and reads the HASH window out to the digest stream, highest word first.
// An STS read showing derr or faultinjdet, or a wait phase that hits POLL_LIMIT reads, makes it write
// CTL.abort and return to IDLE with err_o set. No digest words are output for that job.
//
// Ports
//   clk_i, resetn_i                 clock, asynchronous active-low reset
//   wr_o/waddr_o/wdata_o, wr_ack_i  register write port (request held until acknowledged)
//   rd_o/raddr_o, rdata_i,
//   read_valid_i, rd_ack_o          register read port (request held until data valid, then ack strobe)
//   job_start_i, opcode_i           job start pulse and CFG opcode, sampled only in IDLE
//   msg_data_i/valid_i/last_i,
//   msg_ready_o                     message word stream in
//   dig_data_o/valid_o/last_o,
//   dig_ready_i                     digest word stream out
//   busy_o, err_o                   job in progress, sticky job error
`ifndef FIQSHA_BUS
`define FIQSHA_BUS 32
`endif
module lw_sha_bus_host_sequencer #(
  parameter int FIQSHA_BUS_DATA_WIDTH = `FIQSHA_BUS,
  parameter int DIGEST_WORDS          = 8,
  parameter int POLL_LIMIT            = 1024
) (
  input  logic                             clk_i,
  input  logic                             resetn_i,
  output logic                             wr_o,
  output logic [11:0]                      waddr_o,
  output logic [FIQSHA_BUS_DATA_WIDTH-1:0] wdata_o,
  input  logic                             wr_ack_i,
  output logic                             rd_o,
  output logic [11:0]                      raddr_o,
  input  logic [FIQSHA_BUS_DATA_WIDTH-1:0] rdata_i,
  input  logic                             read_valid_i,
  output logic                             rd_ack_o,
  input  logic                             job_start_i,
  input  logic [3:0]                       opcode_i,
  input  logic [FIQSHA_BUS_DATA_WIDTH-1:0] msg_data_i,
  input  logic                             msg_valid_i,
  input  logic                             msg_last_i,
  output logic                             msg_ready_o,
  output logic [FIQSHA_BUS_DATA_WIDTH-1:0] dig_data_o,
  output logic                             dig_valid_o,
  output logic                             dig_last_o,
  input  logic                             dig_ready_i,
  output logic                             busy_o,
  output logic                             err_o
);
  localparam int BW = FIQSHA_BUS_DATA_WIDTH;
  localparam int IW = (DIGEST_WORDS > 1) ? $clog2(DIGEST_WORDS) : 1;
  // one spare count so the counter can reach POLL_LIMIT itself without wrapping
  localparam int CW = $clog2(POLL_LIMIT + 1);
  localparam logic [11:0] A_CFG  = 12'h010;
  localparam logic [11:0] A_CTL  = 12'h020;
  localparam logic [11:0] A_STS  = 12'h030;
  localparam logic [11:0] A_HASH = 12'h100;
  localparam logic [11:0] A_DIN  = 12'h140;
  localparam logic [11:0] HSTEP  = 12'(BW / 8);
  localparam logic [BW-1:0] CTL_INIT  = {{(BW-3){1'b0}}, 3'b001};
  localparam logic [BW-1:0] CTL_LAST  = {{(BW-3){1'b0}}, 3'b010};
  localparam logic [BW-1:0] CTL_ABORT = {{(BW-3){1'b0}}, 3'b100};

  typedef enum logic [3:0] {
    S_IDLE, S_WR_CFG, S_WR_INIT, S_POLL_RDY, S_GET_MSG, S_WR_DIN,
    S_WR_LAST, S_POLL_AVL, S_RD_HASH, S_OUT_DIG, S_WR_ABORT
  } state_e;

  state_e          state_q, state_d;
  logic            done_q, done_d;
  logic [BW-1:0]   rdata_q, rdata_d;
  logic [BW-1:0]   msg_q, msg_d;
  logic            last_q, last_d;
  logic [3:0]      op_q, op_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;
  logic            is_wr, is_rd, sts_err, sts_ok, last_poll;
  logic [11:0]     wa, ra;
  logic [BW-1:0]   wd;

  // done_q marks the cycle after a bus handshake: the request is dropped (the mandatory idle cycle),
  // the captured read data is evaluated and the FSM moves on.
  assign is_wr = state_q inside {S_WR_CFG, S_WR_INIT, S_WR_DIN, S_WR_LAST, S_WR_ABORT};
  assign is_rd = state_q inside {S_POLL_RDY, S_POLL_AVL, S_RD_HASH};
  assign wa = (state_q == S_WR_CFG) ? A_CFG : (state_q == S_WR_DIN) ? A_DIN : A_CTL;
  assign wd = (state_q == S_WR_CFG)  ? {{(BW-4){1'b0}}, op_q} :
              (state_q == S_WR_DIN)  ? msg_q :
              (state_q == S_WR_INIT) ? CTL_INIT :
              (state_q == S_WR_LAST) ? CTL_LAST : CTL_ABORT;
  assign ra = (state_q == S_RD_HASH) ? A_HASH + HSTEP * 12'(idx_q) : A_STS;

  assign wr_o        = is_wr & ~done_q;
  assign waddr_o     = wr_o ? wa : '0;
  assign wdata_o     = wr_o ? wd : '0;
  assign rd_o        = is_rd & ~done_q;
  assign raddr_o     = rd_o ? ra : '0;
  assign rd_ack_o    = is_rd & done_q;
  assign msg_ready_o = state_q == S_GET_MSG;
  assign dig_valid_o = state_q == S_OUT_DIG;
  assign dig_data_o  = dig_valid_o ? rdata_q : '0;
  assign dig_last_o  = dig_valid_o & (idx_q == '0);
  assign busy_o      = state_q != S_IDLE;
  assign err_o       = err_q;

  // STS: bit0 avl, bit1 rdyd, bit3 derr, bit5 faultinjdet
  assign sts_err   = rdata_q[3] | rdata_q[5];
  assign sts_ok    = (state_q == S_POLL_RDY) ? rdata_q[1] : rdata_q[0];
  assign last_poll = cnt_q == CW'(POLL_LIMIT - 1);

  always_comb begin
    state_d = state_q;
    done_d  = (wr_o & wr_ack_i) | (rd_o & read_valid_i);
    rdata_d = (rd_o & read_valid_i) ? rdata_i : rdata_q;
    msg_d   = msg_q;
    last_d  = last_q;
    op_d    = op_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: if (job_start_i) begin
        state_d = S_WR_CFG;
        op_d    = opcode_i;
        err_d   = 1'b0;
      end
      S_WR_CFG: if (done_q) state_d = S_WR_INIT;
      S_WR_INIT: if (done_q) begin
        state_d = S_POLL_RDY;
        cnt_d   = '0;
      end
      S_POLL_RDY, S_POLL_AVL: if (done_q) begin
        cnt_d = cnt_q + 1'b1;
        idx_d = IW'(DIGEST_WORDS - 1);
        if (sts_err || (!sts_ok && last_poll)) begin
          state_d = S_WR_ABORT;
          err_d   = 1'b1;
        end else if (sts_ok) begin
          state_d = (state_q == S_POLL_RDY) ? S_GET_MSG : S_RD_HASH;
        end
      end
      S_GET_MSG: if (msg_valid_i) begin
        msg_d   = msg_data_i;
        last_d  = msg_last_i;
        state_d = S_WR_DIN;
      end
      S_WR_DIN: if (done_q) begin
        state_d = last_q ? S_WR_LAST : S_POLL_RDY;
        cnt_d   = '0;
      end
      S_WR_LAST: if (done_q) begin
        state_d = S_POLL_AVL;
        cnt_d   = '0;
      end
      S_RD_HASH: if (done_q) state_d = S_OUT_DIG;
      S_OUT_DIG: if (dig_ready_i) begin
        state_d = (idx_q == '0) ? S_IDLE : S_RD_HASH;
        idx_d   = (idx_q == '0) ? idx_q : idx_q - 1'b1;
      end
      S_WR_ABORT: if (done_q) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q <= S_IDLE;
      done_q  <= 1'b0;
      rdata_q <= '0;
      msg_q   <= '0;
      last_q  <= 1'b0;
      op_q    <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
      msg_q   <= msg_d;
      last_q  <= last_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_lw_sha_bus_host_sequencer.sv
// tb_lw_sha_bus_host_sequencer: scoreboard bench with a scripted register-interface slave model.
module tb_lw_sha_bus_host_sequencer;
  logic        clk_i = 1'b0;
  logic        resetn_i = 1'b0;
  logic        wr_o, rd_o, rd_ack_o, msg_ready_o, dig_valid_o, dig_last_o, busy_o, err_o;
  logic [11:0] waddr_o, raddr_o;
  logic [31:0] wdata_o, dig_data_o;
  logic        wr_ack_i = 1'b0, read_valid_i = 1'b0, job_start_i = 1'b0;
  logic        msg_valid_i = 1'b0, msg_last_i = 1'b0, dig_ready_i = 1'b1;
  logic [31:0] rdata_i = '0, msg_data_i = '0;
  logic [3:0]  opcode_i = '0;

  always #5 clk_i = ~clk_i;

  lw_sha_bus_host_sequencer #(.FIQSHA_BUS_DATA_WIDTH(32), .DIGEST_WORDS(8), .POLL_LIMIT(16)) dut (
    .clk_i(clk_i), .resetn_i(resetn_i),
    .wr_o(wr_o), .waddr_o(waddr_o), .wdata_o(wdata_o), .wr_ack_i(wr_ack_i),
    .rd_o(rd_o), .raddr_o(raddr_o), .rdata_i(rdata_i), .read_valid_i(read_valid_i), .rd_ack_o(rd_ack_o),
    .job_start_i(job_start_i), .opcode_i(opcode_i),
    .msg_data_i(msg_data_i), .msg_valid_i(msg_valid_i), .msg_last_i(msg_last_i), .msg_ready_o(msg_ready_o),
    .dig_data_o(dig_data_o), .dig_valid_o(dig_valid_o), .dig_last_o(dig_last_o), .dig_ready_i(dig_ready_i),
    .busy_o(busy_o), .err_o(err_o)
  );

  typedef struct {
    int          kind;
    logic [11:0] addr;
    logic [31:0] data;
    logic        last;
  } ev_t;

  ev_t         exp_q[$];
  logic [31:0] sts_q[$];
  logic [32:0] msgs[$];
  int          checks = 0, errors = 0, dcnt = 0;
  logic        wr_seen = 0, rd_seen = 0, rd_hs = 0, msg_hs = 0, stall_en = 0, stalled = 0;
  logic [31:0] held;

  function automatic logic [31:0] hv(input int i);
    return 32'hD1C0_0000 + 32'(i) * 32'h0000_1111;
  endfunction

  function automatic void exp_w(input logic [11:0] a, input logic [31:0] d);
    ev_t e;
    e.kind = 0; e.addr = a; e.data = d; e.last = 1'b0;
    exp_q.push_back(e);
  endfunction

  function automatic void exp_r(input logic [11:0] a);
    ev_t e;
    e.kind = 1; e.addr = a; e.data = '0; e.last = 1'b0;
    exp_q.push_back(e);
  endfunction

  function automatic void exp_d(input logic [31:0] d, input logic l);
    ev_t e;
    e.kind = 2; e.addr = '0; e.data = d; e.last = l;
    exp_q.push_back(e);
  endfunction

  // slave: acks writes and returns read data one cycle after the request appears; STS replies are scripted
  // (default rdyd|avl), HASH word i returns hv(i); also drives the message stream from msgs
  always @(posedge clk_i) begin
    #1;
    wr_ack_i = wr_o && wr_seen && !wr_ack_i;
    wr_seen = wr_o && !wr_ack_i;
    read_valid_i = rd_o && rd_seen && !read_valid_i;
    rd_seen = rd_o && !read_valid_i;
    rdata_i = '0;
    if (read_valid_i) begin
      if (raddr_o == 12'h030) rdata_i = (sts_q.size() != 0) ? sts_q.pop_front() : 32'h3;
      else rdata_i = hv((int'(raddr_o) - 256) / 4);
    end
    if (msg_hs) void'(msgs.pop_front());
    msg_hs = 1'b0;
    msg_valid_i = msgs.size() != 0;
    {msg_last_i, msg_data_i} = msg_valid_i ? msgs[0] : 33'h0;
  end

  task automatic check_ev(input int k, input logic [11:0] a, input logic [31:0] d, input logic l);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL event: got kind %0d addr %h data %h last %0d, expected nothing", k, a, d, l);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.addr !== a || e.data !== d || e.last !== l) begin
        errors++;
        $display("FAIL event: got kind %0d addr %h data %h last %0d, expected kind %0d addr %h data %h last %0d",
                 k, a, d, l, e.kind, e.addr, e.data, e.last);
      end
    end
  endtask

  // monitor: every completed write, read and digest handshake is compared against the scoreboard
  always @(negedge clk_i) begin
    if (rd_hs) begin
      checks++;
      if (rd_ack_o !== 1'b1 || rd_o !== 1'b0) begin
        errors++;
        $display("FAIL rd_ack: rd_ack_o %b rd_o %b, expected 1 0", rd_ack_o, rd_o);
      end
    end
    rd_hs = rd_o && read_valid_i;
    if (wr_o && wr_ack_i) check_ev(0, waddr_o, wdata_o, 1'b0);
    if (rd_hs) begin
      check_ev(1, raddr_o, 32'h0, 1'b0);
      checks++;
      if (msg_ready_o !== 1'b0) begin
        errors++;
        $display("FAIL msg_ready_during_read: got %b, expected 0", msg_ready_o);
      end
    end
    if (dig_valid_o && dig_ready_i) begin
      check_ev(2, 12'h0, dig_data_o, dig_last_o);
      dcnt++;
    end
    msg_hs = msg_valid_i && msg_ready_o;
  end

  // digest sink backpressure: holds dig_ready_i low for 10 cycles on the third digest word
  always @(posedge clk_i) begin
    #2;
    if (stall_en && !stalled && dig_valid_o && dcnt == 2) begin
      stalled = 1'b1;
      dig_ready_i = 1'b0;
      held = dig_data_o;
      repeat (10) begin
        @(negedge clk_i);
        checks++;
        if (dig_data_o !== held || dig_valid_o !== 1'b1 || rd_o !== 1'b0) begin
          errors++;
          $display("FAIL stall: data %h valid %b rd_o %b, expected %h 1 0", dig_data_o, dig_valid_o, rd_o, held);
        end
      end
      @(posedge clk_i);
      #2;
      dig_ready_i = 1'b1;
    end
  end

  task automatic check_idle_outputs(input string name);
    checks++;
    if ({wr_o, waddr_o, wdata_o, rd_o, raddr_o, rd_ack_o, msg_ready_o, dig_data_o, dig_valid_o, dig_last_o,
         busy_o, err_o} !== '0) begin
      errors++;
      $display("FAIL %s: wr %b waddr %h wdata %h rd %b raddr %h ack %b mrdy %b dig %h dv %b dl %b busy %b err %b, expected all 0",
               name, wr_o, waddr_o, wdata_o, rd_o, raddr_o, rd_ack_o, msg_ready_o, dig_data_o, dig_valid_o,
               dig_last_o, busy_o, err_o);
    end
  endtask

  task automatic pulse_start(input logic [3:0] op);
    @(posedge clk_i);
    #1;
    job_start_i = 1'b1;
    opcode_i = op;
    @(posedge clk_i);
    #1;
    job_start_i = 1'b0;
    opcode_i = '0;
  endtask

  // mode 0: normal digest, 1: derr during POLL_AVL, 2: avl never set (poll timeout)
  task automatic job(input logic [3:0] op, input int nw, input int extra, input int mode, input bit poke);
    logic [31:0] m;
    int t;
    exp_w(12'h010, {28'h0, op});
    exp_w(12'h020, 32'h1);
    for (int w = 0; w < nw; w++) begin
      m = 32'hCAFE_0000 + 32'(op) * 32'h100 + 32'(w);
      if (w == 1) for (int k = 0; k < extra; k++) begin
        sts_q.push_back(32'h0);
        exp_r(12'h030);
      end
      sts_q.push_back(32'h2);
      exp_r(12'h030);
      exp_w(12'h140, m);
      msgs.push_back({w == nw - 1, m});
    end
    exp_w(12'h020, 32'h2);
    if (mode == 0) begin
      sts_q.push_back(32'h1);
      exp_r(12'h030);
      for (int i = 7; i >= 0; i--) begin
        exp_r(12'h100 + 12'(4 * i));
        exp_d(hv(i), i == 0);
      end
    end else if (mode == 1) begin
      sts_q.push_back(32'h0);
      exp_r(12'h030);
      sts_q.push_back(32'h8);
      exp_r(12'h030);
      exp_w(12'h020, 32'h4);
    end else begin
      for (int k = 0; k < 16; k++) begin
        sts_q.push_back(32'h0);
        exp_r(12'h030);
      end
      exp_w(12'h020, 32'h4);
    end
    dcnt = 0;
    pulse_start(op);
    if (poke) begin
      repeat (20) @(posedge clk_i);
      pulse_start(4'hF);
    end
    t = 0;
    while (busy_o && t < 3000) begin
      @(negedge clk_i);
      t++;
    end
    checks++;
    if (busy_o) begin
      errors++;
      $display("FAIL job_done: busy_o still %b after %0d cycles, expected 0", busy_o, t);
    end
    repeat (3) @(negedge clk_i);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover: %0d expected events not seen, expected 0", exp_q.size());
    end
    checks++;
    if (err_o !== (mode != 0)) begin
      errors++;
      $display("FAIL err_o: got %b, expected %b", err_o, mode != 0);
    end
    exp_q.delete();
    sts_q.delete();
    msgs.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    repeat (2) @(negedge clk_i);
    check_idle_outputs("reset_state");
    resetn_i = 1'b1;
    repeat (2) @(negedge clk_i);
    // reset while the first DIN write is in flight
    exp_w(12'h010, 32'h3);
    exp_w(12'h020, 32'h1);
    sts_q.push_back(32'h2);
    exp_r(12'h030);
    msgs.push_back({1'b0, 32'h1111_2222});
    pulse_start(4'h3);
    t = 0;
    while (!(wr_o && waddr_o == 12'h140) && t < 200) begin
      @(negedge clk_i);
      t++;
    end
    checks++;
    if (t >= 200) begin
      errors++;
      $display("FAIL reach_din: DIN write not seen within %0d cycles, expected it", t);
    end
    resetn_i = 1'b0;
    @(negedge clk_i);
    check_idle_outputs("mid_job_reset");
    msgs.delete();
    sts_q.delete();
    @(negedge clk_i);
    resetn_i = 1'b1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pre_reset_events: %0d events not seen, expected 0", exp_q.size());
    end
    exp_q.delete();
    repeat (2) @(negedge clk_i);
    job(4'h1, 3, 0, 0, 1'b1);
    job(4'h2, 3, 5, 0, 1'b0);
    job(4'h5, 2, 0, 1, 1'b0);
    job(4'h6, 1, 0, 2, 1'b0);
    stall_en = 1'b1;
    job(4'h7, 2, 0, 0, 1'b0);
    stall_en = 1'b0;
    checks++;
    if (stalled !== 1'b1) begin
      errors++;
      $display("FAIL stall_seen: got %b, expected 1", stalled);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
